// File: rtl/julia_iter_ctrl_if.sv
// rtl/julia_iter_ctrl_if.sv - pixel request, iteration-stage and result signals of julia_iter_ctrl
// master = surrounding pipeline (generator, JuliaCalc stage, colour mapper); slave = controller.
interface julia_iter_ctrl_if #(
    parameter int ITER_W = 8
) ();
    logic                in_valid;
    logic                in_ready;
    logic signed [31:0]  in_x;
    logic signed [31:0]  in_y;
    logic signed [31:0]  in_cr;
    logic signed [31:0]  in_ci;

    logic                calc_en;
    logic signed [31:0]  calc_x;
    logic signed [31:0]  calc_y;
    logic signed [31:0]  calc_cr;
    logic signed [31:0]  calc_ci;
    logic                calc_end;
    logic signed [31:0]  calc_wx;
    logic signed [31:0]  calc_wy;
    logic signed [31:0]  calc_res;

    logic                out_valid;
    logic                out_ready;
    logic [ITER_W-1:0]   out_iter;
    logic                out_escaped;

    modport master (
        output in_valid, in_x, in_y, in_cr, in_ci,
        input  in_ready,
        input  calc_en, calc_x, calc_y, calc_cr, calc_ci,
        output calc_end, calc_wx, calc_wy, calc_res,
        input  out_valid, out_iter, out_escaped,
        output out_ready
    );

    modport slave (
        input  in_valid, in_x, in_y, in_cr, in_ci,
        output in_ready,
        output calc_en, calc_x, calc_y, calc_cr, calc_ci,
        input  calc_end, calc_wx, calc_wy, calc_res,
        output out_valid, out_iter, out_escaped,
        input  out_ready
    );
endinterface

// File: rtl/julia_iter_ctrl.sv
// rtl/julia_iter_ctrl.sv - per-pixel Julia iteration controller (escape test, iteration count)
// Optional: JL_SKIP_OUTSIDE_EN skips pixels whose z0 lies outside |x|,|y| <= 2.0.
module julia_iter_ctrl #(
    parameter int SCALE     = 1000,
    parameter int MAX_ITER  = 255,
    parameter int ITER_W    = 8,
    parameter int ESC_LIMIT = 4000000
) (
    input  logic              clk,
    input  logic              rst,
    julia_iter_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

`ifdef JL_SKIP_OUTSIDE_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    localparam logic signed [31:0] W_LIMIT   = 32'(2 * SCALE);
    localparam logic signed [31:0] W_ESC     = 32'(ESC_LIMIT);
    localparam logic [ITER_W-1:0]  W_MAX_IT  = ITER_W'(MAX_ITER);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ITER_W-1:0]   r_iter;
    logic                r_escaped;
    logic                r_skip;
    logic signed [31:0]  r_x, r_y, r_cr, r_ci;

    logic                w_outside;
    logic                w_skip;
    logic [ITER_W-1:0]   w_iter_inc;
    logic                w_esc;
    logic                w_max;

    assign w_outside  = (bus.in_x > W_LIMIT) || (bus.in_x < -W_LIMIT) ||
                        (bus.in_y > W_LIMIT) || (bus.in_y < -W_LIMIT);
    assign w_skip     = SKIP_EN && w_outside;
    assign w_iter_inc = r_iter + 1'b1;
    // A negative sum of squares can only come from 32-bit wrap, i.e. far outside.
    assign w_esc      = (bus.calc_res > W_ESC) || (bus.calc_res < 0);
    assign w_max      = (w_iter_inc == W_MAX_IT);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.calc_en   = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // A skipped pixel passes through RUN for one cycle without enabling the stage.
                bus.calc_en = !r_skip;
                if (r_skip)
                    w_state_nxt = S_DONE;
                else if (bus.calc_end)
                    w_state_nxt = (w_esc || w_max) ? S_DONE : S_GAP;
            end
            S_GAP: w_state_nxt = S_RUN;
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iter    <= '0;
            r_escaped <= 1'b0;
            r_skip    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_cr      <= '0;
            r_ci      <= '0;
        end else if (r_state == S_IDLE && bus.in_valid) begin
            r_iter    <= '0;
            r_escaped <= w_skip;
            r_skip    <= w_skip;
            r_x       <= bus.in_x;
            r_y       <= bus.in_y;
            r_cr      <= bus.in_cr;
            r_ci      <= bus.in_ci;
        end else if (r_state == S_RUN && !r_skip && bus.calc_end) begin
            r_iter    <= w_iter_inc;
            r_escaped <= w_esc;
            r_x       <= bus.calc_wx;
            r_y       <= bus.calc_wy;
        end
    end

    assign bus.calc_x      = r_x;
    assign bus.calc_y      = r_y;
    assign bus.calc_cr     = r_cr;
    assign bus.calc_ci     = r_ci;
    assign bus.out_iter    = r_iter;
    assign bus.out_escaped = r_escaped;
endmodule

// File: tb/tb_julia_iter_ctrl.sv
// tb/tb_julia_iter_ctrl.sv - randomized self-checking bench for julia_iter_ctrl
// Honours JL_SKIP_OUTSIDE_EN in the reference model when it is defined.
module tb_julia_iter_ctrl;
    localparam int SCALE     = 1000;
    localparam int MAX_ITER  = 255;
    localparam int ESC_LIMIT = 4000000;
    localparam int LAT_LIM   = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    julia_iter_ctrl_if #(.ITER_W(8)) bus ();

    julia_iter_ctrl #(.SCALE(SCALE), .MAX_ITER(MAX_ITER), .ITER_W(8), .ESC_LIMIT(ESC_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic signed [31:0] f_wx(int x, int y, int cr);
        return 32'((longint'(x) * x - longint'(y) * y) / SCALE + cr);
    endfunction
    function automatic logic signed [31:0] f_wy(int x, int y, int ci);
        return 32'((2 * longint'(x) * y) / SCALE + ci);
    endfunction
    function automatic logic signed [31:0] f_res(int wx, int wy);
        return 32'(longint'(wx) * wx + longint'(wy) * wy);
    endfunction

    // JuliaCalc stage stand-in: result registered one cycle after enable, cleared when enable low.
    always @(posedge clk) begin
        if (rst || !bus.calc_en) begin
            bus.calc_end <= 1'b0;
        end else begin
            bus.calc_end <= 1'b1;
            bus.calc_wx  <= f_wx(bus.calc_x, bus.calc_y, bus.calc_cr);
            bus.calc_wy  <= f_wy(bus.calc_x, bus.calc_y, bus.calc_ci);
            bus.calc_res <= f_res(f_wx(bus.calc_x, bus.calc_y, bus.calc_cr),
                                  f_wy(bus.calc_x, bus.calc_y, bus.calc_ci));
        end
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Escape-time iteration of the Julia map: count of iterations and whether it escaped.
    function automatic int ref_iters(int x0, int y0, int cr, int ci, output bit esc);
        int x = x0;
        int y = y0;
        int nx;
        int r;
`ifdef JL_SKIP_OUTSIDE_EN
        if (x0 > 2 * SCALE || x0 < -2 * SCALE || y0 > 2 * SCALE || y0 < -2 * SCALE) begin
            esc = 1'b1;
            return 0;
        end
`endif
        for (int n = 1; n <= MAX_ITER; n++) begin
            nx = f_wx(x, y, cr);
            y  = f_wy(x, y, ci);
            x  = nx;
            r  = f_res(x, y);
            if (r > ESC_LIMIT || r < 0) begin
                esc = 1'b1;
                return n;
            end
        end
        esc = 1'b0;
        return MAX_ITER;
    endfunction

    task automatic run_pixel(input string tag, input int x, input int y, input int cr, input int ci,
                             input int hold);
        bit esc_exp;
        int n_exp;
        int lat_exp;
        int edges = 0;
        bit saw_en = 1'b0;
        n_exp   = ref_iters(x, y, cr, ci, esc_exp);
        lat_exp = (n_exp == 0) ? 1 : 3 * n_exp - 1;

        @(negedge clk);
        check({tag, "_in_ready_idle"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_x = x; bus.in_y = y; bus.in_cr = cr; bus.in_ci = ci;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        while (bus.out_valid !== 1'b1 && edges < LAT_LIM) begin
            if (bus.calc_en === 1'b1) saw_en = 1'b1;
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_latency"}, edges, lat_exp);
        check({tag, "_iter"}, bus.out_iter, n_exp);
        check({tag, "_escaped"}, bus.out_escaped, esc_exp);
        check({tag, "_calc_en_used"}, saw_en, n_exp != 0);

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, bus.out_valid, 1);
            check({tag, "_hold_iter"}, bus.out_iter, n_exp);
            check({tag, "_hold_in_ready"}, bus.in_ready, 0);
        end

        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, bus.out_valid, 0);
        check({tag, "_in_ready_back"}, bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x = 0; bus.in_y = 0; bus.in_cr = 0; bus.in_ci = 0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_calc_en", bus.calc_en, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_iter", bus.out_iter, 0);
        check("rst_out_escaped", bus.out_escaped, 0);
        check("rst_calc_x", bus.calc_x, 0);

        run_pixel("origin", 0, 0, 0, 0, 0);
        run_pixel("far", 3000, 0, 0, 0, 0);
        run_pixel("backpressure", 3000, 0, 0, 0, 20);
        run_pixel("edge2500", 2500, 0, 0, 0, 1);
        run_pixel("neg_wrap", -46000, 0, 0, 0, 0);

        // Reset pulse in the middle of a long pixel.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_x = 0; bus.in_y = 0; bus.in_cr = 0; bus.in_ci = 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_calc_en", bus.calc_en, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_output", bus.out_valid, 0);
        run_pixel("after_rst", 3000, 0, 0, 0, 0);

        for (int k = 0; k < 20; k++) begin
            run_pixel($sformatf("rnd%0d", k),
                      int'($urandom_range(0, 5000)) - 2500, int'($urandom_range(0, 5000)) - 2500,
                      int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000,
                      int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
